// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: memory-op codes, bus size codes and FSM encodings shared by the mem_stage slice
package mem_stage_pkg;
  localparam int MMOP_W = 4;
  localparam logic [MMOP_W-1:0] MMOP_NOP = 4'd0, MMOP_LB = 4'd1, MMOP_LBU = 4'd2, MMOP_LH = 4'd3,
    MMOP_LHU = 4'd4, MMOP_LW = 4'd5, MMOP_SB = 4'd6, MMOP_SH = 4'd7, MMOP_SW = 4'd8,
    MMOP_LWL = 4'd9, MMOP_LWR = 4'd10, MMOP_SWL = 4'd11, MMOP_SWR = 4'd12;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3, S_DRAIN = 3'd4;
endpackage

// File: rtl/mem_align.sv
// mem_align: load extract/extend and store strobe/data generation; MEM_UNALIGNED_EN adds LWL/LWR/SWL/SWR
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [MMOP_W-1:0] op,
  input  logic [1:0]        addr,
  input  logic [31:0]       storedata,
  input  logic [31:0]       rdata,
  output logic              is_load,
  output logic              is_store,
  output logic              misaligned,
  output logic              is_nop,
  output logic [1:0]        size,
  output logic [3:0]        wstrb,
  output logic [31:0]       wdata,
  output logic [31:0]       ldata
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sh;
  always_comb begin
    sh = {addr, 3'b000};
    b = rdata[sh+:8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    is_load = op inside {MMOP_LB, MMOP_LBU, MMOP_LH, MMOP_LHU, MMOP_LW};
    is_store = op inside {MMOP_SB, MMOP_SH, MMOP_SW};
    misaligned = (op inside {MMOP_LH, MMOP_LHU, MMOP_SH} && addr[0]) || (op inside {MMOP_LW, MMOP_SW} && |addr);
    is_nop = 1'b0;
    size = op inside {MMOP_LB, MMOP_LBU, MMOP_SB} ? SZ_B : op inside {MMOP_LH, MMOP_LHU, MMOP_SH} ? SZ_H : SZ_W;
    wstrb = op == MMOP_SB ? 4'b0001 << addr : op == MMOP_SH ? 4'b0011 << addr : 4'hF;
    wdata = op == MMOP_SB ? {4{storedata[7:0]}} : op == MMOP_SH ? {2{storedata[15:0]}} : storedata;
    ldata = op == MMOP_LB ? {{24{b[7]}}, b} : op == MMOP_LBU ? {24'd0, b} :
            op == MMOP_LH ? {{16{h[15]}}, h} : op == MMOP_LHU ? {16'd0, h} : rdata;
`ifdef MEM_UNALIGNED_EN
    is_load = is_load || op inside {MMOP_LWL, MMOP_LWR};
    is_store = is_store || op inside {MMOP_SWL, MMOP_SWR};
    wstrb = op == MMOP_SWL ? 4'b1111 >> (2'd3 - addr) : op == MMOP_SWR ? 4'b1111 << addr : wstrb;
    wdata = op == MMOP_SWL ? storedata >> (5'd24 - sh) : op == MMOP_SWR ? storedata << sh : wdata;
    ldata = op == MMOP_LWL ? (rdata << (5'd24 - sh)) | (storedata & (32'hFFFF_FFFF >> ({1'b0, sh} + 6'd8))) :
            op == MMOP_LWR ? (rdata >> sh) | (storedata & ~(32'hFFFF_FFFF >> sh)) : ldata;
`else
    is_nop = op inside {MMOP_LWL, MMOP_LWR, MMOP_SWL, MMOP_SWR};
`endif
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving an SRAM-like data bus; MEM_UNALIGNED_EN enables LWL/LWR/SWL/SWR
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_flush_i,
  input  logic              mem_stall_i,
  input  logic              mem_wren_i,
  input  logic [4:0]        mem_waddr_i,
  input  logic [DATA_W-1:0] mem_alures_i,
  input  logic [DATA_W-1:0] mem_storedata_i,
  input  logic [MMOP_W-1:0] mem_memop_i,
  input  logic [31:0]       mem_inst_i,
  input  logic              mem_inslot_i,
  input  logic [31:0]       mem_pc_i,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              mem_adel_o,
  output logic              mem_ades_o,
  output logic [31:0]       mem_badvaddr_o,
  output logic              mem_wren_o,
  output logic [4:0]        mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [31:0]       mem_inst_o,
  output logic              mem_inslot_o,
  output logic [31:0]       mem_pc_o,
  output logic              mem_stallreq_o
);
  logic [2:0]        state, state_nx;
  logic              is_load, is_store, misaligned, is_nop, err, issue, fin;
  logic [DATA_W-1:0] ldata, hold, result;
  mem_align u_align (
    .op(mem_memop_i), .addr(mem_alures_i[1:0]), .storedata(mem_storedata_i), .rdata(data_rdata),
    .is_load(is_load), .is_store(is_store), .misaligned(misaligned), .is_nop(is_nop),
    .size(data_size), .wstrb(data_wstrb), .wdata(data_wdata), .ldata(ldata)
  );
  assign data_wr = is_store;
  assign data_addr = mem_memop_i inside {MMOP_LWL, MMOP_LWR, MMOP_SWL, MMOP_SWR} ? {mem_alures_i[31:2], 2'b00} : mem_alures_i;
  always_comb begin
    err = (is_load || is_store) && misaligned;
    issue = state == S_IDLE && (is_load || is_store) && !misaligned && !mem_flush_i;
    data_req = issue || state == S_REQ;
    fin = data_data_ok && (state == S_WAIT || (data_req && data_addr_ok));
    mem_stallreq_o = data_req ? !(data_addr_ok && data_data_ok) : state == S_WAIT ? !data_data_ok : state == S_DRAIN;
    // a flush with the address already accepted must still swallow the pending response
    state_nx = state == S_DRAIN ? (data_data_ok ? S_IDLE : S_DRAIN) :
               state == S_DONE ? (mem_flush_i || !mem_stall_i ? S_IDLE : S_DONE) :
               mem_flush_i && state != S_IDLE ? ((state == S_WAIT || data_addr_ok) && !data_data_ok ? S_DRAIN : S_IDLE) :
               fin ? (mem_stall_i ? S_DONE : S_IDLE) :
               data_req ? (data_addr_ok ? S_WAIT : S_REQ) : state;
    result = state == S_DONE ? hold : is_load ? ldata : mem_alures_i;
  end
  always_ff @(posedge clk) begin
    state <= rst ? S_IDLE : state_nx;
    if (rst) hold <= '0;
    else if (fin && mem_stall_i && !mem_flush_i) hold <= ldata;
  end
  always_ff @(posedge clk) begin
    if (rst || mem_flush_i) begin
      mem_adel_o <= 1'b0;
      mem_ades_o <= 1'b0;
      mem_badvaddr_o <= '0;
      mem_wren_o <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
      mem_inst_o <= '0;
      mem_inslot_o <= 1'b0;
      mem_pc_o <= RESET_PC;
    end else if (!mem_stall_i) begin
      mem_adel_o <= err && is_load;
      mem_ades_o <= err && is_store;
      mem_badvaddr_o <= err ? mem_alures_i : '0;
      mem_wren_o <= mem_wren_i && !is_store && !err && !is_nop;
      mem_waddr_o <= mem_waddr_i;
      mem_wdata_o <= result;
      mem_inst_o <= mem_inst_i;
      mem_inslot_o <= mem_inslot_i;
      mem_pc_o <= mem_pc_i;
    end
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of execute: consumes the registered execute outputs (write-back info, ALU result, mem op, inst, delay-slot flag).
- Drives an SRAM-like data bus (req/addr_ok/data_ok), aligns load data, and forms store byte strobes.
- Raises a stall request while a bus transaction is outstanding.
- Registers the result toward write-back.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- RESET_PC, 32'hBFC0_0000, value of mem_pc_o after reset/flush.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- mem_flush_i  in  1  from controller; kills the instruction in this stage.
- mem_stall_i  in  1  from controller; holds the output register; already ORed with mem_stallreq_o.
- mem_wren_i  in  1  register write enable.
- mem_waddr_i  in  5  destination register.
- mem_alures_i  in  32  ALU result; this is the effective address for loads and stores.
- mem_storedata_i  in  32  rt value for stores, and the merge base for LWL/LWR.
- mem_memop_i  in  MMOP_W  memory op code.
- mem_inst_i  in  32  instruction word.
- mem_inslot_i  in  1  delay-slot flag.
- mem_pc_i  in  32  instruction PC.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  byte address.
- data_wstrb  out  4  byte strobes.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response valid.
- data_rdata  in  32  load data.
- mem_adel_o  out  1  load address error, registered.
- mem_ades_o  out  1  store address error, registered.
- mem_badvaddr_o  out  32  faulting address, registered.
- mem_wren_o  out  1  registered write enable to write-back.
- mem_waddr_o  out  5  registered destination register.
- mem_wdata_o  out  32  registered result to write-back.
- mem_inst_o  out  32  registered instruction word.
- mem_inslot_o  out  1  registered delay-slot flag.
- mem_pc_o  out  32  registered PC.
- mem_stallreq_o  out  1  combinational stall request.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE.
  - All registered outputs are 0, except mem_pc_o = RESET_PC.
  - The hold buffer is cleared.
- FSM states:
  - IDLE (no transaction)
  - REQ (data_req=1, waiting for addr_ok)
  - WAIT (waiting for data_ok)
  - DONE (response captured, held while mem_stall_i)
  - DRAIN (flushed, absorbing an orphan data_ok)
- IDLE:
  - A load/store op with aligned address and no flush asserts data_req combinationally in the same cycle.
  - addr_ok=1 -> WAIT; addr_ok=0 -> REQ.
  - Non-memory ops never touch the bus: 1-cycle latency, mem_wdata_o = mem_alures_i.
- REQ:
  - data_req, addr, size, wstrb and wdata are held stable until addr_ok.
  - On addr_ok -> WAIT.
  - A flush while in REQ with addr_ok=0 drops the request -> IDLE.
  - A flush with addr_ok=1 in the same cycle -> DRAIN.
- WAIT:
  - On data_ok with mem_stall_i=0 -> IDLE; the output register captures the result that edge.
  - On data_ok with mem_stall_i=1 -> DONE; aligned data goes into the hold buffer.
  - Flush in WAIT -> DRAIN.
- DONE: when mem_stall_i=0, the output register loads from the hold buffer -> IDLE.
- DRAIN: data_req=0; on data_ok -> IDLE; the response is discarded.
- mem_stallreq_o:
  - 1 in REQ and WAIT without data_ok, and in DRAIN.
  - 1 in IDLE when a request is issued without same-cycle data_ok.
  - 0 otherwise.
  - data_ok and addr_ok in the same cycle as the request are legal and complete in 1 cycle.
- Output register update:
  - rst or flush -> cleared.
  - Else if !mem_stall_i -> loads the current result.
  - Else holds its value.
- Alignment and address errors:
  - LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - On violation: no bus request, ADEL/ADES set, badvaddr = address, mem_wren_o forced 0.
- Loads:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - data_addr is the unmasked byte address.
- Stores:
  - SB: wstrb = 1<<addr[1:0], byte replicated ×4.
  - SH: wstrb = 4'b0011<<addr[1:0], half replicated ×2.
  - SW: 4'hF.
  - Stores force mem_wren_o=0.

Optional Feature:
- Macro MEM_UNALIGNED_EN.
- Defined: LWL/LWR/SWL/SWR are supported, little-endian MIPS.
  - data_size=2 with word-aligned address.
  - LWL/LWR merge with mem_storedata_i.
  - SWL wstrb = 4'b1111>>(3-addr[1:0]); SWR wstrb = 4'b1111<<addr[1:0]; data is shifted accordingly.
- Undefined: these opcodes are treated as NOP (no bus access, wren forced 0).

Decomposition:
- Shared package/defines header holds:
  - MMOP_W=4 and MMOP codes: NOP=0, LB, LBU, LH, LHU, LW, SB, SH, SW, LWL, LWR, SWL, SWR.
  - Size codes.
  - FSM state encodings.
- One sub-module, mem_align: purely combinational load extract/extend and store strobe/data generation.

Test Plan:
- ALU op, mem_alures_i=32'h1234, wren=1, waddr=5 -> next edge: mem_wdata_o=32'h1234, data_req never asserted.
- LB at 0x...0003, rdata=32'h80FF_FF00, addr_ok/data_ok 2 cycles apart -> stallreq high 2 cycles, mem_wdata_o=32'hFFFF_FF80.
- SH at 0x...0002, rt=32'hABCD_1234 -> wstrb=4'b1100, wdata=32'h1234_1234, mem_wren_o=0.
- LW at 0x...0002 -> no req, mem_adel_o=1, mem_badvaddr_o=0x...0002, mem_wren_o=0.
- LW, flush asserted in WAIT, data_ok 3 cycles later -> DRAIN, stallreq=1 until data_ok, outputs remain cleared, next op issues only afterwards.
- LHU completes with mem_stall_i=1 for 2 extra cycles, rdata=32'h8001_0000 at addr[1]=1 -> DONE holds, then mem_wdata_o=32'h0000_8001.
